// File: rtl/pla_inverse_search.sv
// pla_inverse_search
// Inverse-lookup engine for an external combinational PLA. For each request it
// drives every input vector 0..2^IN_W-1 onto pla_x, compares the PLA outputs
// against a masked target word, and reports the lowest matching vector and the
// number of matching vectors.
// Optional build macro: PLA_SEARCH_EARLY_EXIT_EN -- stop the sweep at the first
// hit (rsp_count is then 1 on a hit, 0 otherwise).
module pla_inverse_search #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OUT_W-1:0] req_target,
   input  logic [OUT_W-1:0] req_mask,
   output logic [IN_W-1:0]  pla_x,
   input  logic [OUT_W-1:0] pla_z,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_found,
   output logic [IN_W-1:0]  rsp_x,
   output logic [IN_W:0]    rsp_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [IN_W-1:0] X_ONE     = {{(IN_W-1){1'b0}}, 1'b1};
   localparam logic [IN_W:0]   COUNT_ONE = {{IN_W{1'b0}}, 1'b1};

   state_t           state_reg,     state_next;
   logic [IN_W-1:0]  pla_x_reg,     pla_x_next;
   logic [IN_W-1:0]  rsp_x_reg,     rsp_x_next;
   logic [IN_W:0]    count_reg,     count_next;
   logic [OUT_W-1:0] target_reg,    target_next;
   logic [OUT_W-1:0] mask_reg,      mask_next;
   logic             found_reg,     found_next;
   logic             rsp_valid_reg, rsp_valid_next;
   logic             req_ready_reg, req_ready_next;

   logic [OUT_W-1:0] diff;
   logic             hit;
   logic             last_x;

   // Per-bit masked mismatch between the PLA output and the latched target.
   genvar gi;
   generate
      for (gi = 0; gi < OUT_W; gi++) begin : g_cmp
         assign diff[gi] = (pla_z[gi] ^ target_reg[gi]) & mask_reg[gi];
      end
   endgenerate

   assign hit    = ~|diff;
   assign last_x = &pla_x_reg;

   // Every output comes straight from a register.
   assign req_ready = req_ready_reg;
   assign pla_x     = pla_x_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_found = found_reg;
   assign rsp_x     = rsp_x_reg;
   assign rsp_count = count_reg;

   // State and datapath registers; reset discards any partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         pla_x_reg     <= '0;
         rsp_x_reg     <= '0;
         count_reg     <= '0;
         target_reg    <= '0;
         mask_reg      <= '0;
         found_reg     <= 1'b0;
         rsp_valid_reg <= 1'b0;
         req_ready_reg <= 1'b1;
      end else begin
         state_reg     <= state_next;
         pla_x_reg     <= pla_x_next;
         rsp_x_reg     <= rsp_x_next;
         count_reg     <= count_next;
         target_reg    <= target_next;
         mask_reg      <= mask_next;
         found_reg     <= found_next;
         rsp_valid_reg <= rsp_valid_next;
         req_ready_reg <= req_ready_next;
      end
   end

   // Next-state and next-register values; everything holds unless changed.
   always_comb begin
      state_next     = state_reg;
      pla_x_next     = pla_x_reg;
      rsp_x_next     = rsp_x_reg;
      count_next     = count_reg;
      target_next    = target_reg;
      mask_next      = mask_reg;
      found_next     = found_reg;
      rsp_valid_next = rsp_valid_reg;
      req_ready_next = req_ready_reg;

      case (state_reg)
         IDLE: begin
            req_ready_next = 1'b1;
            if (req_valid && req_ready_reg) begin
               target_next    = req_target;
               mask_next      = req_mask;
               count_next     = '0;
               found_next     = 1'b0;
               rsp_x_next     = '0;
               pla_x_next     = '0;
               req_ready_next = 1'b0;
               state_next     = SWEEP;
            end
         end

         SWEEP: begin
            req_ready_next = 1'b0;
            // pla_x wraps to 0 naturally after the last vector.
            pla_x_next = pla_x_reg + X_ONE;
`ifdef PLA_SEARCH_EARLY_EXIT_EN
            if (hit) begin
               // First hit ends the search immediately.
               count_next     = COUNT_ONE;
               found_next     = 1'b1;
               rsp_x_next     = pla_x_reg;
               pla_x_next     = '0;
               rsp_valid_next = 1'b1;
               state_next     = RESP;
            end else if (last_x) begin
               rsp_valid_next = 1'b1;
               state_next     = RESP;
            end
`else
            if (hit) begin
               count_next = count_reg + COUNT_ONE;
               if (!found_reg) begin
                  // Sweep is ascending, so the first hit is the lowest vector.
                  rsp_x_next = pla_x_reg;
                  found_next = 1'b1;
               end
            end
            if (last_x) begin
               rsp_valid_next = 1'b1;
               state_next     = RESP;
            end
`endif
         end

         RESP: begin
            req_ready_next = 1'b0;
            if (rsp_valid_reg && rsp_ready) begin
               // Result registers keep their values until the next accept.
               rsp_valid_next = 1'b0;
               req_ready_next = 1'b1;
               state_next     = IDLE;
            end
         end

         default: begin
            state_next     = IDLE;
            pla_x_next     = '0;
            rsp_valid_next = 1'b0;
            req_ready_next = 1'b1;
         end
      endcase
   end

endmodule

// File: doc/pla_inverse_search.md
Name: pla_inverse_search

Overview:
- Sequential inverse-lookup engine for a generated two-level PLA block: an 8-input, 16-output combinational function.
- Takes a requested output word and a care mask, then sweeps every input vector through an externally instantiated PLA.
- Reports the first input vector whose outputs match, and the total number of matching vectors.
- Sits beside a generated PLA as its reverse-direction driver. Used for characterization, equivalence spot checks and input recovery.

Parameters:
- IN_W, 8, PLA input width; sweep covers 2^IN_W vectors.
- OUT_W, 16, PLA output width; width of target and mask.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request offered.
- req_ready  output  1  engine idle, can accept a request.
- req_target  input  OUT_W  required PLA output word.
- req_mask  input  OUT_W  care mask; bit=1 means compare, bit=0 means don't-care.
- pla_x  output  IN_W  registered input vector driven to the external PLA x0..x(IN_W-1); bit 0 = x0.
- pla_z  input  OUT_W  PLA outputs z00..z(OUT_W-1), combinational from pla_x; bit 0 = z00.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  result consumed.
- rsp_found  output  1  at least one match.
- rsp_x  output  IN_W  lowest matching input vector; 0 if none.
- rsp_count  output  IN_W+1  number of matching vectors, 0..2^IN_W.

Behaviour:
- States: IDLE, SWEEP, RESP.
- Reset (async, rst_n=0), all outputs registered:
  - state=IDLE, req_ready=1, pla_x=0, rsp_valid=0, rsp_found=0, rsp_x=0, rsp_count=0.
  - target/mask registers and internal counters are cleared.
- IDLE:
  - req_ready=1.
  - Request is accepted on an edge with req_valid&&req_ready: latch target and mask, clear count/found/rsp_x, set pla_x=0, go to SWEEP, req_ready←0.
- SWEEP:
  - Each cycle compares ((pla_z ^ target) & mask)==0 for the current pla_x.
  - On a hit: count+1, and if found==0 then rsp_x←pla_x and found←1.
  - pla_x increments by 1 each edge.
  - At the edge evaluating pla_x=2^IN_W-1: capture the final compare, pla_x wraps to 0, rsp_valid←1, go to RESP.
- Latency: rsp_valid is first high 2^IN_W edges after the accepting edge (256 for defaults). The PLA settle path is a single cycle, pla_x register to compare.
- RESP:
  - rsp_* held stable while rsp_valid=1.
  - Response completes on an edge with rsp_valid&&rsp_ready: rsp_valid←0, req_ready←1, go to IDLE. rsp_found/rsp_x/rsp_count keep their values until the next accept.
  - req_ready=0 throughout SWEEP and RESP; req_valid is ignored there.
- mask=0: every vector matches; count=2^IN_W, rsp_x=0, found=1.
- Count width IN_W+1 holds the full 2^IN_W without wrap.
- Reset mid-SWEEP or mid-RESP: immediate return to the reset values; the partial result is discarded.
- Request must not be accepted in the same edge a response completes; the earliest accept is the edge after RESP exit.

Optional Feature:
- Macro: PLA_SEARCH_EARLY_EXIT_EN.
- Defined:
  - SWEEP ends at the edge that records the first hit; that hit is captured, rsp_valid←1, go to RESP.
  - rsp_count = 1 on a hit, 0 if no hit.
  - pla_x←0 on exit.
  - Latency = (hit index + 1) edges, or 2^IN_W with no hit.
- Undefined: full sweep as described in Behaviour.

Test Plan:
- Stub PLA z={8'h00,x}; target 16'h0005, mask 16'hFFFF → rsp_valid after 256 edges, rsp_found=1, rsp_x=5, rsp_count=1.
- Stub PLA; target 16'h0000, mask 16'hFF00 → rsp_found=1, rsp_x=0, rsp_count=256.
- Stub PLA; target 16'h0100, mask 16'hFFFF → rsp_found=0, rsp_x=0, rsp_count=0.
- Stub PLA; hold rsp_ready=0 for 10 cycles after rsp_valid, and pulse req_valid during that window → rsp_* stable, req_ready=0, request ignored; req_ready=1 the edge after the rsp handshake.
- Assert rst_n=0 at sweep cycle 100 → pla_x=0, rsp_valid=0, req_ready=1 immediately. A new request after release gives the same results as the first test.
- With PLA_SEARCH_EARLY_EXIT_EN, stub PLA, target 16'h0005 mask 16'hFFFF → rsp_valid after 6 edges, rsp_x=5, rsp_count=1.
